// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the two-channel FIFO read scheduler.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int BURST_LEN_DEFAULT = 16;

endpackage

// File: rtl/fifo_sched_skid.sv
// Two-entry tagged output buffer (data, channel, start-of-burst); entry 0 is
// always the head, and the occupancy is exported so the parent can throttle reads.
module fifo_sched_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_b_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_ch_i,
    input  logic                  push_sof_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic                  head_ch_o,
    output logic                  head_sof_o,
    output logic                  head_valid_o,
    output logic [1:0]            occ_o
);

    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] ent0_q, ent0_d;
    logic [EW-1:0] ent1_q, ent1_d;
    logic [EW-1:0] push_ent;
    logic [1:0]    occ_q, occ_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        push_ent = {push_sof_i, push_ch_i, push_data_i};
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        occ_d    = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_ent;
                else               ent1_d = push_ent;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_ent;
                end else begin
                    ent0_d = push_ent;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            // NOTE: payload entries are reset too, so out_data_o reads 0 straight out of reset.
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign {head_sof_o, head_ch_o, head_data_o} = ent0_q;
    assign head_valid_o = (occ_q != 2'd0);
    assign occ_o        = occ_q;

    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_b_i)
        occ_q <= 2'd2);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_b_i)
        !(push_i && !pop_i && occ_q == 2'd2));

endmodule

// File: rtl/fifo_read_scheduler.sv
// Round-robin burst reader for two I/Q sample FIFOs feeding one valid/ready stream.
// Define FIFO_SCHED_STRICT_PRIO_EN to make channel 0 win every contested grant.
module fifo_read_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = BURST_LEN_DEFAULT,
    parameter int CNT_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_b_i,
    input  logic                  enable_i,
    input  logic                  ch0_empty_i,
    output logic                  ch0_rd_en_o,
    input  logic [DATA_WIDTH-1:0] ch0_rd_data_i,
    input  logic                  ch1_empty_i,
    output logic                  ch1_rd_en_o,
    input  logic [DATA_WIDTH-1:0] ch1_rd_data_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_ch_o,
    output logic                  out_sof_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  busy_o
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    sched_state_e     state_q, state_d;
    logic             sel_ch_q, sel_ch_d;
    logic             last_ch_q, last_ch_d;
    logic             inflight_q, inflight_d;
    logic             sof_pend_q, sof_pend_d;
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;

    logic [1:0] empty;
    logic [1:0] occ;
    logic [2:0] pending;
    logic       pop;
    logic       issue;
    logic       grant_ch;

    assign empty = {ch1_empty_i, ch0_empty_i};
    assign pop   = out_valid_o && out_ready_i;

    // Words already owed to the buffer after this cycle's pop; a new read only
    // goes out if it still fits in the two entries.
    assign pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue   = (state_q == BURST) && !empty[sel_ch_q]
                     && (issued_cnt_q < BURST_MAX) && (pending < 3'd2);

    assign ch0_rd_en_o = issue && (sel_ch_q == CH0);
    assign ch1_rd_en_o = issue && (sel_ch_q == CH1);
    assign busy_o      = (state_q != IDLE);

`ifdef FIFO_SCHED_STRICT_PRIO_EN
    assign grant_ch = ch0_empty_i ? CH1 : CH0;
`else
    always_comb begin
        if (!ch0_empty_i && !ch1_empty_i) grant_ch = ~last_ch_q;
        else                              grant_ch = ch0_empty_i ? CH1 : CH0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        sel_ch_d     = sel_ch_q;
        last_ch_d    = last_ch_q;
        issued_cnt_d = issue ? issued_cnt_q + CNT_W'(1) : issued_cnt_q;
        inflight_d   = issue;
        sof_pend_d   = issue && (issued_cnt_q == '0);
        case (state_q)
            IDLE: begin
                if (enable_i && (!ch0_empty_i || !ch1_empty_i)) begin
                    state_d      = BURST;
                    sel_ch_d     = grant_ch;
                    issued_cnt_d = '0;
                end
            end
            BURST: begin
                // A burst that has not issued yet keeps waiting rather than ending empty.
                if (issued_cnt_d == BURST_MAX
                    || (empty[sel_ch_q] && issued_cnt_q != '0)) begin
                    state_d   = DRAIN;
                    last_ch_d = sel_ch_q;
                end
            end
            DRAIN: begin
                if (!inflight_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q      <= IDLE;
            sel_ch_q     <= CH0;
            last_ch_q    <= CH1;
            issued_cnt_q <= '0;
            inflight_q   <= 1'b0;
            sof_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_ch_q     <= sel_ch_d;
            last_ch_q    <= last_ch_d;
            issued_cnt_q <= issued_cnt_d;
            inflight_q   <= inflight_d;
            sof_pend_q   <= sof_pend_d;
        end
    end

    // sel_ch_q only moves in IDLE, after DRAIN has seen the last read land.
    fifo_sched_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_b_i     (rst_b_i),
        .push_i      (inflight_q),
        .push_data_i (sel_ch_q ? ch1_rd_data_i : ch0_rd_data_i),
        .push_ch_i   (sel_ch_q),
        .push_sof_i  (sof_pend_q),
        .pop_i       (pop),
        .head_data_o (out_data_o),
        .head_ch_o   (out_ch_o),
        .head_sof_o  (out_sof_o),
        .head_valid_o(out_valid_o),
        .occ_o       (occ)
    );

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Scoreboard bench for fifo_read_scheduler: behavioural FIFOs feed the DUT,
// a burst model fills the expected queue and a monitor checks every accepted word.
`timescale 1ns/1ps
module tb_fifo_read_scheduler;

    localparam int DW = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst_b_i;
    logic          enable_i;
    logic          ch0_empty_i, ch1_empty_i;
    logic          ch0_rd_en_o, ch1_rd_en_o;
    logic [DW-1:0] ch0_rd_data_i, ch1_rd_data_i;
    logic [DW-1:0] out_data_o;
    logic          out_ch_o, out_sof_o, out_valid_o, out_ready_i, busy_o;

    always #5 clk = ~clk;

    fifo_read_scheduler #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL),
        .CNT_W     (8)
    ) dut (
        .clk_i        (clk),
        .rst_b_i      (rst_b_i),
        .enable_i     (enable_i),
        .ch0_empty_i  (ch0_empty_i),
        .ch0_rd_en_o  (ch0_rd_en_o),
        .ch0_rd_data_i(ch0_rd_data_i),
        .ch1_empty_i  (ch1_empty_i),
        .ch1_rd_en_o  (ch1_rd_en_o),
        .ch1_rd_data_i(ch1_rd_data_i),
        .out_data_o   (out_data_o),
        .out_ch_o     (out_ch_o),
        .out_sof_o    (out_sof_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          ch;
        logic          sof;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic last_m = 1'b1;
    int   seq = 0;
    int   out_n = 0;
    int   max_out = 0;
    bit   ch1_seen = 0;
    bit   both_seen = 0;
    int   rd_count = 0;
    int   first_rd_ch = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_b_i) begin
            exp_q.delete();
        end else if (out_valid_o && out_ready_i) begin
            check("scoreboard_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("word", 64'({out_data_o, out_ch_o, out_sof_o}), 64'(mon_e));
            end
        end
    end

    // One clock of the behavioural FIFOs plus ready generation.
    task automatic tick();
        logic [1:0] rd_s;
        int         pops;
        @(negedge clk);
        rd_s = {ch1_rd_en_o, ch0_rd_en_o};
        pops = (out_valid_o && out_ready_i) ? 1 : 0;
        if (!rst_b_i) begin
            out_n = 0;
        end else begin
            out_n = out_n + int'(rd_s[0]) + int'(rd_s[1]) - pops;
            if (out_n > max_out) max_out = out_n;
        end
        if (rd_s[1]) ch1_seen = 1;
        if (&rd_s) both_seen = 1;
        if (rd_s != 2'b00) begin
            rd_count++;
            if (first_rd_ch < 0) first_rd_ch = rd_s[1] ? 1 : 0;
        end
        @(posedge clk);
        #1;
        if (rd_s[0] && q0.size() != 0) ch0_rd_data_i = q0.pop_front();
        if (rd_s[1] && q1.size() != 0) ch1_rd_data_i = q1.pop_front();
        ch0_empty_i = (q0.size() == 0);
        ch1_empty_i = (q1.size() == 0);
        case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b0;
        endcase
    endtask

    task automatic load(input int n0, input int n1);
        for (int i = 0; i < n0; i++) begin
            q0.push_back({8'hA0, 24'(seq)});
            seq++;
        end
        for (int i = 0; i < n1; i++) begin
            q1.push_back({8'hB1, 24'(seq)});
            seq++;
        end
    endtask

    // Expected word order for FIFO contents loaded up front, up to max_bursts grants.
    task automatic model_bursts(input int max_bursts);
        logic [DW-1:0] c0[$];
        logic [DW-1:0] c1[$];
        logic          ch;
        int            b;
        c0 = q0;
        c1 = q1;
        b  = 0;
        while ((c0.size() != 0 || c1.size() != 0) && b < max_bursts) begin
`ifdef FIFO_SCHED_STRICT_PRIO_EN
            ch = (c0.size() != 0) ? 1'b0 : 1'b1;
`else
            if (c0.size() != 0 && c1.size() != 0) ch = ~last_m;
            else                                  ch = (c0.size() != 0) ? 1'b0 : 1'b1;
`endif
            for (int i = 0; i < BL; i++) begin
                if (ch == 1'b0 && c0.size() != 0)
                    exp_q.push_back('{data: c0.pop_front(), ch: 1'b0, sof: (i == 0)});
                else if (ch == 1'b1 && c1.size() != 0)
                    exp_q.push_back('{data: c1.pop_front(), ch: 1'b1, sof: (i == 0)});
            end
            last_m = ch;
            b++;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(exp_q.size() == 0 && !busy_o && !out_valid_o)) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size() == 0 && !busy_o && !out_valid_o), 64'd1);
    endtask

    initial begin
        int c0, c1, c2;
        rst_b_i       = 1'b0;
        enable_i      = 1'b0;
        ch0_empty_i   = 1'b1;
        ch1_empty_i   = 1'b1;
        ch0_rd_data_i = '0;
        ch1_rd_data_i = '0;
        out_ready_i   = 1'b1;
        #1;
        check("reset_ctrl", 64'({busy_o, out_valid_o, out_sof_o, out_ch_o, ch1_rd_en_o, ch0_rd_en_o}), 64'd0);
        check("reset_data", 64'(out_data_o), 64'd0);
        tick();
        tick();
        rst_b_i  = 1'b1;
        enable_i = 1'b1;

        // Both FIFOs empty: the scheduler must stay idle.
        for (int i = 0; i < 5; i++) tick();
        check("idle_empty_busy", 64'(busy_o), 64'd0);
        check("idle_empty_rd", 64'(rd_count), 64'd0);

        // Channel 0 only, 40 words: bursts of 16, 16, 8.
        ch1_seen = 0;
        load(40, 0);
        model_bursts(100);
        wait_drain("drain_ch0_only", 2000);
        check("no_ch1_rd_en", 64'(ch1_seen), 64'd0);

        // Both channels 32 words: alternating (or strict-priority) 16-word bursts.
        load(32, 32);
        model_bursts(100);
        wait_drain("drain_both_32", 2000);

        // Channel 0 runs dry after 5 words, then channel 1 is granted.
        load(5, 8);
        model_bursts(100);
        wait_drain("drain_early_term", 1000);

        // Downstream stalls for ten cycles mid-burst.
        load(20, 0);
        model_bursts(100);
        for (int i = 0; i < 6; i++) tick();
        ready_mode = 2;
        tick();
        c0 = rd_count;
        for (int i = 0; i < 5; i++) tick();
        c1 = rd_count;
        for (int i = 0; i < 5; i++) tick();
        c2 = rd_count;
        check("stall_issue_le_2", 64'((c2 - c0) <= 2), 64'd1);
        check("stall_rd_en_quiet", 64'(c2 - c1), 64'd0);
        check("stall_valid_held", 64'(out_valid_o), 64'd1);
        ready_mode = 0;
        wait_drain("drain_after_stall", 1000);

        // enable_i drops mid-burst: that burst completes, then nothing more.
        load(20, 0);
        model_bursts(1);
        for (int i = 0; i < 6; i++) tick();
        enable_i = 1'b0;
        wait_drain("drain_enable_drop", 1000);
        for (int i = 0; i < 5; i++) tick();
        check("disabled_stays_idle", 64'(busy_o), 64'd0);
        check("disabled_words_left", 64'(q0.size()), 64'd4);
        enable_i = 1'b1;
        model_bursts(100);
        wait_drain("drain_reenable", 1000);

        // 1000 words with random backpressure.
        load(500, 500);
        model_bursts(1000);
        ready_mode = 1;
        wait_drain("drain_random_ready", 20000);
        ready_mode = 0;
        check("max_outstanding_le_2", 64'(max_out <= 2), 64'd1);
        check("never_both_rd_en", 64'(both_seen), 64'd0);

        // Asynchronous reset in the middle of a burst.
        load(10, 10);
        model_bursts(100);
        for (int i = 0; i < 5; i++) tick();
        check("busy_before_reset", 64'(busy_o), 64'd1);
        #2;
        rst_b_i = 1'b0;
        #1;
        check("midrst_ctrl", 64'({busy_o, out_valid_o, out_sof_o, out_ch_o, ch1_rd_en_o, ch0_rd_en_o}), 64'd0);
        check("midrst_data", 64'(out_data_o), 64'd0);
        tick();
        tick();
        last_m      = 1'b1;
        rst_b_i     = 1'b1;
        first_rd_ch = -1;
        model_bursts(100);
        wait_drain("drain_after_reset", 1000);
        check("first_grant_after_reset", 64'(first_rd_ch), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_read_scheduler.md
Name: fifo_read_scheduler

Overview:
- Shares one output stream between the read sides of two complex (I/Q) sample FIFOs: channel 0 (sub-GHz) and channel 1 (2.4 GHz).
- Grants bursts of up to BURST_LEN words per channel, round-robin, and drives each FIFO's rd_en.
- Captures the FIFO's registered read data (1-cycle latency) into a 2-entry output buffer with valid/ready toward the host readout interface.
- Sits in the read-clock domain, alongside the FIFOs.

Parameters:
- DATA_WIDTH, 32, complex word width ({I[15:0], Q[15:0]}), matches FIFO read data.
- BURST_LEN, 16, maximum words issued per grant; legal range 1..255.
- CNT_W, 8, burst counter width; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk_i  in  1  read-side clock, shared with both FIFOs' read clocks.
- rst_b_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  permits new grants; an ongoing burst always completes.
- ch0_empty_i  in  1  channel 0 FIFO empty flag.
- ch0_rd_en_o  out  1  channel 0 FIFO read enable.
- ch0_rd_data_i  in  DATA_WIDTH  channel 0 FIFO read data, valid the cycle after ch0_rd_en_o.
- ch1_empty_i, ch1_rd_en_o, ch1_rd_data_i  same as above, for channel 1.
- out_data_o  out  DATA_WIDTH  buffered sample.
- out_ch_o  out  1  channel tag of out_data_o.
- out_sof_o  out  1  out_data_o is the first word of its burst.
- out_valid_o  out  1  out_data_o/out_ch_o/out_sof_o are valid.
- out_ready_i  in  1  downstream accepts the word when out_valid_o && out_ready_i.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_b_i=0): state=IDLE; all outputs 0; buffer occupancy=0; in-flight=0; last_ch=1, so channel 0 wins the first arbitration.
- States: IDLE, BURST, DRAIN.
- IDLE -> BURST when enable_i && (!ch0_empty_i || !ch1_empty_i).
  - Grant goes to the non-empty channel.
  - If both are non-empty, grant goes to the channel != last_ch.
  - The grant registers sel_ch and clears issued_cnt.
- BURST, issue rule: rd_en for sel_ch = !empty[sel_ch] && issued_cnt < BURST_LEN && (occ + inflight − pop) < 2.
  - pop = out_valid_o && out_ready_i.
  - The other channel's rd_en stays 0.
  - Each issue increments issued_cnt and sets inflight=1 for the next cycle.
- BURST -> DRAIN when issued_cnt reaches BURST_LEN, or when empty[sel_ch]=1 with issued_cnt ≥ 1 (early termination).
  - The same cycle sets last_ch=sel_ch.
- DRAIN -> IDLE once inflight=0; buffered words may still be pending.
- Capture: in the cycle after an issue, rd_data[sel_ch] is written into the buffer tail, tagged with sel_ch.
  - sof=1 iff that word was issue #1 of its burst.
- Buffer: 2-entry FIFO; head drives the out_* outputs.
  - Simultaneous push and pop is allowed.
  - Occupancy never exceeds 2; the issue rule guarantees this, and an assertion checks it.
- Throughput: 1 word/cycle sustained while out_ready_i=1 and the FIFO is non-empty.
  - out_valid_o rises 2 cycles after the first rd_en.
- out_ready_i held low: issuance stalls after the buffer fills; no word is lost or duplicated.
- enable_i dropping mid-burst: the burst runs to BURST or early termination, then DRAIN, then IDLE stays idle.
- Both channels empty in IDLE: remain in IDLE with no rd_en.
- issued_cnt saturates logic at BURST_LEN; no counter wraps within a burst.
- Reset mid-burst: everything clears immediately and buffered words are discarded.

Optional Feature:
- Macro: FIFO_SCHED_STRICT_PRIO_EN.
- Defined: channel 0 always wins when both channels are non-empty; last_ch is ignored.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package fifo_sched_pkg holds:
  - state enum {IDLE, BURST, DRAIN};
  - channel ID constants CH0=1'b0, CH1=1'b1;
  - default BURST_LEN.
- Sub-module fifo_sched_skid: 2-entry tagged output buffer (data, ch, sof) exposing occupancy to the parent.

Test Plan:
- Ch0 holds 40 words, ch1 empty, ready=1, BURST_LEN=16 -> bursts of 16, 16, 8 from ch0 only; sof on words 0, 16, 32; no rd_en on ch1.
- Both channels hold 32 words -> grants alternate ch0, ch1, ch0, ch1, each 16 words, tags correct. Under FIFO_SCHED_STRICT_PRIO_EN, all 32 ch0 words come out before any ch1 word.
- Ch0 empties after 5 words of a burst -> early termination, exactly 5 words out, then ch1 is granted.
- ready=0 for 10 cycles mid-burst -> at most 2 words buffered, rd_en stalls, all words are delivered in order once ready returns.
- Random ready toggling over 1000 words -> output sequence equals input per channel; occupancy never exceeds 2.
- rst_b_i asserted mid-burst -> all outputs 0 with no clock edge; after release, the first grant goes to ch0.
